operand_loader: RTL and testbench

Operand entry sequencer placed between the board push-button and switches and the structural ALU. It debounces one active-low key, turns each clean press into a one-cycle strobe, and uses a three-state FSM to capture the switch value as operand x and then as operand y. It presents both registered operands with a valid flag, so the ALU always sees a stable, complete operand pair.

---
 rtl/operand_loader_pkg.sv | 19 +
 rtl/button_debouncer.sv | 81 ++++++++
 rtl/operand_loader.sv | 117 +++++++++++
 tb/tb_operand_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_loader_pkg.sv
// -----------------------------------------------------------------------------
// operand_loader_pkg
//
// Shared definitions for the operand entry sequencer.
//   STATE_W  : width of the FSM state, also the width of the LED state port.
//   state_e  : legal FSM encodings. The remaining code 2'b11 is illegal and is
//              recovered to S_X by the FSM.
// -----------------------------------------------------------------------------
package operand_loader_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_X    = 2'b00,  // waiting for operand x
    S_Y    = 2'b01,  // waiting for operand y
    S_DONE = 2'b10   // x and y form a complete pair
  } state_e;

endpackage : operand_loader_pkg

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Turns one raw, active-low, asynchronous push-button into a single-cycle
// strobe per clean press. Reusable for any key.
//
// Ports
//   clock  in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   key_n  in   raw key, active low, asynchronous to clock
//   press  out  registered one-cycle strobe, one per debounced 1->0 change
//
// Pipeline, with key_n low from just after edge 0:
//   synchronized level low after edge 2, debounced level low after
//   edge 2 + DEBOUNCE_CYCLES, press high after edge 3 + DEBOUNCE_CYCLES.
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000  // must be >= 1
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Count value at which one more disagreeing cycle completes the interval.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;        // [0] first stage, [1] synchronized level
  logic             level_q;       // debounced key level (1 = released)
  logic             level_d;
  logic             level_prev_q;  // debounced level one cycle earlier
  logic [CNT_W-1:0] cnt_q;         // consecutive cycles sync differs from level
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             press_d;

  logic             sync_level;
  assign sync_level = sync_q[1];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave it unassigned and infer a latch.
    level_d = level_q;
    cnt_d   = '0;
    press_d = level_prev_q & ~level_q;  // falling edge only; release is ignored

    // Agreement clears the count (default above); any disagreement that
    // persists for the full interval is accepted as the new level.
    if (sync_level != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_level;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q       <= 2'b11;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value; this is what makes the two sync stages a real shift register.
      sync_q       <= {sync_q[0], key_n};
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule : button_debouncer

// File: rtl/operand_loader.sv
// -----------------------------------------------------------------------------
// operand_loader
//
// Operand entry sequencer between the board key/switches and the ALU. Each
// debounced press captures the switch value, first as x, then as y; the ALU
// sees registered operands plus a valid flag marking a complete pair.
//
// Ports
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   key_n    in   raw push-button, active low
//   data_in  in   switch value, quasi-static, sampled only on the capture edge
//   x        out  registered operand x
//   y        out  registered operand y
//   valid    out  x and y form a complete pair
//   press    out  one-cycle strobe per debounced press
//   state    out  current FSM state for the LEDs
//
// Capture happens on the edge where press is high, i.e. DEBOUNCE_CYCLES + 4
// edges after a stable key fall.
// -----------------------------------------------------------------------------
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               key_n,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   x,
  output logic [WIDTH-1:0]   y,
  output logic               valid,
  output logic               press,
  output logic [STATE_W-1:0] state
);

  logic               press_s;

  // State is held as a raw vector so the illegal code 2'b11 is representable
  // and can be recovered from.
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   x_d;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH-1:0]   y_d;
  logic               valid_q;
  logic               valid_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clock (clock),
    .reset (reset),
    .key_n (key_n),
    .press (press_s)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;

    case (state_q)
      S_X: begin
        if (press_s) begin
          x_d     = data_in;
          state_d = S_Y;
        end
      end
      S_Y: begin
        if (press_s) begin
          y_d     = data_in;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A press here starts a new pair: y keeps its old value until the
        // next press replaces it, but the pair is no longer valid.
        if (press_s) begin
          x_d     = data_in;
          valid_d = 1'b0;
          state_d = S_Y;
        end
      end
      default: begin
        // Illegal code: recover unconditionally, capture nothing.
        state_d = S_X;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_X;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign valid = valid_q;
  assign press = press_s;
  assign state = state_q;

endmodule : operand_loader

// File: tb/tb_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_operand_loader
//
// Self-checking bench for operand_loader with WIDTH = 4, DEBOUNCE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge and outputs are sampled there
// too, so "edge 0" is the edge just before key_n is driven low.
// The reference model works from the behavioural rules: key level seen two
// edges late, a level change accepted after DB consecutive disagreeing
// samples, a strobe one edge after an accepted fall, and operand capture by
// press parity (odd presses of a pair load x, even ones load y).
// -----------------------------------------------------------------------------
module tb_operand_loader;

  localparam int WIDTH = 4;
  localparam int DB    = 4;
  localparam int LAT   = DB + 4;  // key fall to capture edge

  logic             clock   = 1'b0;
  logic             reset   = 1'b0;
  logic             key_n   = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             valid;
  logic             press;
  logic [1:0]       state;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  operand_loader #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .key_n  (key_n),
    .data_in(data_in),
    .x      (x),
    .y      (y),
    .valid  (valid),
    .press  (press),
    .state  (state)
  );

  // ---------------- reference model ----------------
  bit               m_pipe[$];  // key samples still travelling to the debouncer
  bit               m_lvl;
  bit               m_lvl_prev;
  int               m_diff;
  bit               m_press;
  int               m_phase;    // 0 empty, 1 have x, 2 pair complete
  logic [WIDTH-1:0] m_x;
  logic [WIDTH-1:0] m_y;
  bit               m_valid;

  task automatic model_reset();
    m_pipe     = {1'b1, 1'b1};
    m_lvl      = 1'b1;
    m_lvl_prev = 1'b1;
    m_diff     = 0;
    m_press    = 1'b0;
    m_phase    = 0;
    m_x        = '0;
    m_y        = '0;
    m_valid    = 1'b0;
  endtask

  // Advance the model across one rising edge with the inputs present there.
  task automatic model_step(input bit k, input logic [WIDTH-1:0] d);
    bit lvl;
    bit fell;
    if (m_press) begin
      if (m_phase == 1) begin
        m_y     = d;
        m_valid = 1'b1;
        m_phase = 2;
      end else begin
        m_x     = d;
        m_valid = 1'b0;
        m_phase = 1;
      end
    end
    fell       = m_lvl_prev && !m_lvl;
    m_lvl_prev = m_lvl;
    lvl        = m_pipe.pop_front();
    m_pipe.push_back(k);
    if (lvl != m_lvl) m_diff++;
    else              m_diff = 0;
    if (m_diff == DB) begin
      m_lvl  = lvl;
      m_diff = 0;
    end
    m_press = fell;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".x"},     32'(x),     32'(m_x));
    check({tag, ".y"},     32'(y),     32'(m_y));
    check({tag, ".valid"}, 32'(valid), 32'(m_valid));
    check({tag, ".press"}, 32'(press), 32'(m_press));
    check({tag, ".state"}, 32'(state), 32'(m_phase));
  endtask

  task automatic tick();
    if (reset) model_step(key_n, data_in);
    @(posedge clock);
    #1;
  endtask

  // One key press: low for low_len edges, then released, total_len edges in
  // all. The switches hold 'd' only on the capture edge and are random
  // everywhere else, so only the capture-edge value may land in x or y.
  task automatic press_op(input logic [WIDTH-1:0] d, input int low_len,
                          input int total_len, output int npress);
    npress = 0;
    for (int t = 1; t <= total_len; t++) begin
      key_n   = (t <= low_len) ? 1'b0 : 1'b1;
      data_in = (t == LAT) ? d : WIDTH'($urandom);
      tick();
      if (press) npress++;
      check_model("press_op");
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] ex;
    logic [WIDTH-1:0] ey;
    logic             ev;
    logic [1:0]       es;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    int first_press;
    logic [1:0] st_before;

    // Sequence continues from x=5, y=0, state S_Y after the latency test.
    vecs[0] = '{data: 4'hA, ex: 4'h5, ey: 4'hA, ev: 1'b1, es: 2'b10};
    vecs[1] = '{data: 4'h3, ex: 4'h3, ey: 4'hA, ev: 1'b0, es: 2'b01};
    vecs[2] = '{data: 4'h7, ex: 4'h3, ey: 4'h7, ev: 1'b1, es: 2'b10};
    vecs[3] = '{data: 4'hE, ex: 4'hE, ey: 4'h7, ev: 1'b0, es: 2'b01};
    vecs[4] = '{data: 4'h1, ex: 4'hE, ey: 4'h1, ev: 1'b1, es: 2'b10};

    model_reset();

    // ---- reset held 3 cycles with the key toggling ----
    for (int i = 0; i < 3; i++) begin
      key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      check("rst.x",     32'(x),     32'h0);
      check("rst.y",     32'(y),     32'h0);
      check("rst.valid", 32'(valid), 32'h0);
      check("rst.press", 32'(press), 32'h0);
      check("rst.state", 32'(state), 32'h0);
    end
    key_n = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_model("idle");
    end

    // ---- first entry with exact latency ----
    for (int t = 1; t <= 24; t++) begin
      key_n   = (t <= 10) ? 1'b0 : 1'b1;
      data_in = (t == LAT) ? 4'h5 : WIDTH'($urandom);
      tick();
      check("lat.press", 32'(press), (t == LAT - 1) ? 32'h1 : 32'h0);
      check("lat.x",     32'(x),     (t >= LAT) ? 32'h5 : 32'h0);
      check("lat.state", 32'(state), (t >= LAT) ? 32'h1 : 32'h0);
      check_model("lat");
    end

    // ---- table of further entries ----
    for (int i = 0; i < 5; i++) begin
      press_op(vecs[i].data, 10, 22, n);
      check("tbl.npress", 32'(n),     32'h1);
      check("tbl.x",      32'(x),     32'(vecs[i].ex));
      check("tbl.y",      32'(y),     32'(vecs[i].ey));
      check("tbl.valid",  32'(valid), 32'(vecs[i].ev));
      check("tbl.state",  32'(state), 32'(vecs[i].es));
    end

    // ---- bounce: low 3, high 2, low 2, then released ----
    st_before = state;
    n = 0;
    for (int t = 1; t <= 20; t++) begin
      key_n   = (t <= 3) ? 1'b0 : (t <= 5) ? 1'b1 : (t <= 7) ? 1'b0 : 1'b1;
      data_in = WIDTH'($urandom);
      tick();
      if (press) n++;
      check_model("bounce");
    end
    check("bounce.npress", 32'(n),     32'h0);
    check("bounce.state",  32'(state), 32'h2);
    check("bounce.stable", 32'(state), 32'(st_before));

    // ---- long hold: exactly one press, restarts the pair ----
    press_op(4'h9, 50, 62, n);
    check("hold.npress", 32'(n),     32'h1);
    check("hold.x",      32'(x),     32'h9);
    check("hold.y",      32'(y),     32'h1);
    check("hold.valid",  32'(valid), 32'h0);
    check("hold.state",  32'(state), 32'h1);

    // ---- reset mid-debounce ----
    n = 0;
    for (int t = 1; t <= 4; t++) begin
      key_n   = 1'b0;
      data_in = WIDTH'($urandom);
      tick();
      if (press) n++;
    end
    reset = 1'b0;
    model_reset();
    #1;
    check("rmd.async_x",     32'(x),     32'h0);
    check("rmd.async_y",     32'(y),     32'h0);
    check("rmd.async_valid", 32'(valid), 32'h0);
    check("rmd.async_press", 32'(press), 32'h0);
    check("rmd.async_state", 32'(state), 32'h0);
    tick();          // edge 5 with reset still low
    reset = 1'b1;
    first_press = -1;
    for (int t = 6; t <= 25; t++) begin
      key_n   = 1'b0;
      data_in = (t == 13) ? 4'hB : WIDTH'($urandom);
      tick();
      if (press) begin
        n++;
        if (first_press < 0) first_press = t;
      end
      check_model("rmd");
    end
    check("rmd.npress",      32'(n),           32'h1);
    check("rmd.first_press", 32'(first_press), 32'd12);
    check("rmd.x",           32'(x),           32'hB);
    check("rmd.state",       32'(state),       32'h1);
    key_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_model("rmd_rel");
    end

    // ---- random key activity against the model ----
    for (int seg = 0; seg < 40; seg++) begin
      int lo;
      int hi;
      lo = int'($urandom_range(1, 12));
      hi = int'($urandom_range(1, 12));
      for (int t = 0; t < lo + hi; t++) begin
        key_n   = (t < lo) ? 1'b0 : 1'b1;
        data_in = WIDTH'($urandom);
        tick();
        check_model("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_operand_loader
